// File: rtl/gray_pkg.sv
// Shared types, default sizes and the binary-to-Gray helper for the Gray conversion arbiter.
package gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_RESPOND
    } state_t;

    localparam int GRAY_WIDTH = 4;
    localparam int GRAY_N_REQ = 2;
    localparam int GRAY_MAX_W = 32;

    // Callers zero-extend into GRAY_MAX_W and truncate the result back to their width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_conv_core.sv
// Registered binary-to-Gray conversion; the output follows bin_in one clock later.
module gray_conv_core
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin_in,
    output logic [WIDTH-1:0] gray_out
);

    logic [WIDTH-1:0] w_gray;
    logic [WIDTH-1:0] r_gray;

    assign w_gray = WIDTH'(bin2gray(GRAY_MAX_W'(bin_in)));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray <= '0;
        end else begin
            r_gray <= w_gray;
        end
    end

    assign gray_out = r_gray;

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray conversion core between N_REQ requesters.
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH,
    parameter int N_REQ = GRAY_N_REQ
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int ID_W = $clog2(N_REQ);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_grant_id;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] w_core_out;
    logic [ID_W-1:0]  w_pick;
    logic             w_found;
    logic             w_accept;
    logic             w_rsp_done;

    function automatic logic [ID_W-1:0] wrap_idx(input int unsigned v);
        return ID_W'(v % N_REQ);
    endfunction

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[wrap_idx(32'(r_rr_ptr) + k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_idx(32'(r_rr_ptr) + k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst so no accept is advertised while reset is held.
                if (w_found && !rst) begin
                    req_ready[w_pick] = 1'b1;
                    w_accept          = 1'b1;
                    w_state_nxt       = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                w_state_nxt = ST_RESPOND;
            end
            ST_RESPOND: begin
                rsp_valid[r_grant_id] = 1'b1;
                if (rsp_ready[r_grant_id]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: op_reg is reset along with the control state so a discarded request leaves no stale operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_op       <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= req_data[w_pick*WIDTH +: WIDTH];
                r_grant_id <= w_pick;
            end
            // The requester just served drops to lowest priority.
            if (w_rsp_done) begin
                r_rr_ptr <= wrap_idx(32'(r_grant_id) + 32'd1);
            end
        end
    end

    gray_conv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .bin_in   (r_op),
        .gray_out (w_core_out)
    );

    assign rsp_data = w_core_out;
    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: directed scenarios plus randomized rounds with back-pressure.
module tb_gray_conv_arbiter;
    import gray_pkg::*;

    localparam int W = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [N-1:0]   rsp_ready;
    logic           busy;
    logic [0:0]     grant_id;

    logic           bp_rand;
    logic [N-1:0]   bp_force;
    logic [N-1:0]   bp_rand_val;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        int           id;
        logic [W-1:0] gray;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;
    int   m_rr = 0;

    gray_conv_arbiter #(
        .WIDTH(W),
        .N_REQ(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    assign rsp_ready = bp_rand ? bp_rand_val : bp_force;

    always @(posedge clk) begin
        #1;
        bp_rand_val = N'($urandom_range(0, 3));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Gray code: each output bit is the XOR of a bit and its upper neighbour; the MSB passes through.
    function automatic logic [W-1:0] gray_ref(input logic [W-1:0] b);
        logic [W-1:0] g;
        for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
        g[W-1] = b[W-1];
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] bin);
        exp_t e;
        e.id   = id;
        e.gray = gray_ref(bin);
        sb_q.push_back(e);
        m_rr = (id + 1) % N;
    endtask

    // Monitor: one scoreboard entry is consumed per response handshake.
    always @(negedge clk) begin
        if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e_mon = sb_q.pop_front();
                check("rsp_owner", 32'(rsp_valid), 32'(1 << e_mon.id));
                check("rsp_grant", 32'(grant_id), 32'(e_mon.id));
                check("rsp_data", 32'(rsp_data), 32'(e_mon.gray));
            end
        end
    end

    task automatic wait_accept(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        logic [N-1:0] acc;
        int cyc;
        pend = mask;
        cyc  = 0;
        while (pend != '0 && cyc < 100) begin
            @(negedge clk);
            acc = req_ready & req_valid & pend;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
            pend      = pend & ~acc;
            cyc++;
        end
        if (pend != '0) check("accept_timeout", 32'(pend), 32'd0);
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || busy) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_queue", 32'(sb_q.size()), 32'd0);
        check("drain_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // All masked requesters raise valid together; service order is cyclic upward from the model pointer.
    task automatic run_round(input logic [N-1:0] mask, input logic [N*W-1:0] dat);
        int start;
        int id;
        start = m_rr;
        for (int k = 0; k < N; k++) begin
            id = (start + k) % N;
            if (mask[id]) push_exp(id, dat[id*W +: W]);
        end
        req_data  = dat;
        req_valid = mask;
        wait_accept(mask);
        wait_drain();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_data  = '0;
        bp_rand   = 1'b0;
        bp_force  = 2'b11;

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Contention after reset: req0 then req1, twice.
        run_round(2'b11, {4'b1100, 4'b0110});
        run_round(2'b11, {4'b1001, 4'b0011});

        // Single requester latency profile.
        push_exp(0, 4'b1010);
        req_data  = {4'b0000, 4'b1010};
        req_valid = 2'b01;
        @(negedge clk);
        check("t1_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_convert_busy", 32'(busy), 32'd1);
        check("t1_convert_rsp", 32'(rsp_valid), 32'd0);
        check("t1_convert_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_data", 32'(rsp_data), 32'hF);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Back-pressure on req1 while req0 waits; non-owner ready pulse is ignored.
        bp_force  = 2'b00;
        push_exp(1, 4'b1111);
        req_data  = {4'b1111, 4'b0000};
        req_valid = 2'b10;
        wait_accept(2'b10);
        req_data[W-1:0] = 4'b0011;
        req_valid       = 2'b01;
        push_exp(0, 4'b0011);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h2);
            check("bp_rsp_data", 32'(rsp_data), 32'h8);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        bp_force = 2'b01;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("nonowner_rsp_valid", 32'(rsp_valid), 32'h2);
            check("nonowner_grant", 32'(grant_id), 32'd1);
            check("nonowner_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bp_force = 2'b11;
        wait_accept(2'b01);
        wait_drain();

        // Sweep every input value, alternating requesters.
        for (int v = 0; v < 16; v++) begin
            run_round(2'(1 << (v % 2)), {4'(v), 4'(v)});
        end

        // Reset while CONVERT holds 1000: request is discarded.
        req_data  = {4'b0000, 4'b1000};
        req_valid = 2'b01;
        wait_accept(2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        m_rr = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        run_round(2'b11, {4'b1110, 4'b0101});

        // Randomized rounds with random response back-pressure.
        bp_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            run_round(2'($urandom_range(1, 3)), 8'($urandom));
        end
        bp_rand  = 1'b0;
        bp_force = 2'b11;

        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
